snoopy_bus_arbiter: RTL and testbench

SNOOPY_BUS_ARBITER -- requirements
Module: snoopy_bus_arbiter

---
 rtl/snoopy_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_snoopy_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin arbiter for a snoopy cache-coherent bus: IDLE -> SNOOP -> TRANSFER.
// Define BUS_TIMEOUT_EN to abort a TRANSFER that lasts TIMEOUT_CYCLES cycles.
module snoopy_bus_arbiter #(
   parameter int unsigned NUM_CACHES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CACHES-1:0]   busRequest,
   input  logic [2*NUM_CACHES-1:0] busCommandIn,
   input  logic [NUM_CACHES-1:0]   busRelease,
   input  logic [NUM_CACHES-1:0]   snoopRequest,
   input  logic [NUM_CACHES-1:0]   snoopShared,
   input  logic [NUM_CACHES-1:0]   snoopOwned,
   output logic [NUM_CACHES-1:0]   busGrant,
   output logic [1:0]              commandOut,
   output logic                    snoopValid,
   output logic                    sharedIn,
   output logic                    ownedIn,
   output logic [NUM_CACHES-1:0]   supplierSelect,
   output logic                    memorySupply,
   output logic                    busTimeout
);

   localparam int unsigned IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
   localparam logic [NUM_CACHES-1:0] ONE = NUM_CACHES'(1);

   typedef enum logic [1:0] {IDLE, SNOOP, TRANSFER} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_READ, CMD_READ_EX, CMD_INVAL} cmd_t;

   state_t                  state, state_next;
   logic [IDX_W-1:0]        last, win_idx, cand;
   int unsigned             cand_i;
   logic                    win_found;
   logic [NUM_CACHES-1:0]   win_oh, grant_q, others, sup_mask, supp_nx;
   logic [1:0]              cmd_arr [NUM_CACHES];
   cmd_t                    cmd_q;
   logic                    shared_q, owned_q, mem_q, is_inv;
   logic [NUM_CACHES-1:0]   supp_q;
   logic                    release_hit, timeout_hit, end_txn;

   for (genvar g = 0; g < NUM_CACHES; g++) begin : g_cmd
      assign cmd_arr[g] = busCommandIn[2*g +: 2];
   end

   // Search starts one past the last grantee, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last;
      cand_i    = 0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_CACHES; k++) begin
         cand_i = 32'(last) + k;
         if (cand_i >= NUM_CACHES) cand_i = cand_i - NUM_CACHES;
         cand = cand_i[IDX_W-1:0];
         if (!win_found && busRequest[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      win_oh          = '0;
      win_oh[win_idx] = 1'b1;
   end

   // Snoop responses exclude the grantee; supplier is the lowest set bit.
   always_comb begin
      others   = ~grant_q;
      sup_mask = snoopRequest & others;
      is_inv   = (cmd_q == CMD_INVAL);
      supp_nx  = is_inv ? '0 : (sup_mask & (~sup_mask + ONE));
   end

   assign release_hit = (state == TRANSFER) && |(busRelease & grant_q);
   assign end_txn     = release_hit | timeout_hit;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] xfer_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                  xfer_cnt <= '0;
      else if (state == SNOOP)    xfer_cnt <= '0;
      else if (state == TRANSFER) xfer_cnt <= xfer_cnt + CNT_W'(1);
   end

   assign timeout_hit = (state == TRANSFER) && (xfer_cnt == CNT_W'(TIMEOUT_CYCLES));
   assign busTimeout  = timeout_hit;
`else
   assign timeout_hit = 1'b0;
   assign busTimeout  = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (|busRequest) state_next = SNOOP;
         SNOOP:    state_next = TRANSFER;
         TRANSFER: if (end_txn) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last     <= IDX_W'(NUM_CACHES - 1);
         grant_q  <= '0;
         cmd_q    <= CMD_NONE;
         shared_q <= 1'b0;
         owned_q  <= 1'b0;
         supp_q   <= '0;
         mem_q    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (|busRequest) begin
                  grant_q <= win_oh;
                  cmd_q   <= cmd_t'(cmd_arr[win_idx]);
                  last    <= win_idx;
               end
            end
            SNOOP: begin
               shared_q <= !is_inv && |(snoopShared & others);
               owned_q  <= !is_inv && |(snoopOwned & others);
               supp_q   <= supp_nx;
               mem_q    <= !is_inv && (sup_mask == '0);
            end
            TRANSFER: begin
               if (end_txn) begin
                  grant_q  <= '0;
                  cmd_q    <= CMD_NONE;
                  shared_q <= 1'b0;
                  owned_q  <= 1'b0;
                  supp_q   <= '0;
                  mem_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busGrant       = grant_q;
   assign commandOut     = cmd_q;
   assign snoopValid     = (state == SNOOP);
   assign sharedIn       = shared_q;
   assign ownedIn        = owned_q;
   assign supplierSelect = supp_q;
   assign memorySupply   = mem_q;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Self-checking bench for snoopy_bus_arbiter: vector table with expected-result queue,
// plus hand sequences for round-robin, reset abort and the BUS_TIMEOUT_EN option.
module tb_snoopy_bus_arbiter;

   localparam int unsigned N = 4;

   logic         clock, reset;
   logic [N-1:0] busRequest, busRelease, snoopRequest, snoopShared, snoopOwned;
   logic [2*N-1:0] busCommandIn;
   logic [N-1:0] busGrant, supplierSelect;
   logic [1:0]   commandOut;
   logic         snoopValid, sharedIn, ownedIn, memorySupply, busTimeout;

   snoopy_bus_arbiter #(.NUM_CACHES(N), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .busRequest(busRequest), .busCommandIn(busCommandIn), .busRelease(busRelease),
      .snoopRequest(snoopRequest), .snoopShared(snoopShared), .snoopOwned(snoopOwned),
      .busGrant(busGrant), .commandOut(commandOut), .snoopValid(snoopValid),
      .sharedIn(sharedIn), .ownedIn(ownedIn), .supplierSelect(supplierSelect),
      .memorySupply(memorySupply), .busTimeout(busTimeout)
   );

   typedef struct {
      logic [N-1:0]   req;
      logic [2*N-1:0] cmd;
      logic [N-1:0]   sreq, ssh, sow;
      logic [N-1:0]   grant;
      logic [1:0]     ecmd;
      logic           sh_e, ow_e;
      logic [N-1:0]   supp;
      logic           mem;
   } vec_t;

   vec_t         vecs [6];
   vec_t         exp_q [$];
   logic [N-1:0] grant_q [$];
   int           checks = 0;
   int           errors = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic idle_inputs();
      busRequest = '0; busCommandIn = '0; busRelease = '0;
      snoopRequest = '0; snoopShared = '0; snoopOwned = '0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_grant0"}, busGrant, 0);
      chk({tag, "_cmd0"}, commandOut, 0);
      chk({tag, "_sv0"}, snoopValid, 0);
      chk({tag, "_sh0"}, sharedIn, 0);
      chk({tag, "_ow0"}, ownedIn, 0);
      chk({tag, "_supp0"}, supplierSelect, 0);
      chk({tag, "_mem0"}, memorySupply, 0);
      chk({tag, "_to0"}, busTimeout, 0);
   endtask

   // One full transaction from IDLE; release is also pulsed in SNOOP and from
   // non-grantees, both of which must be ignored.
   task automatic run_vec(input int idx, input vec_t v);
      vec_t e;
      string t;
      t = $sformatf("v%0d", idx);
      @(negedge clock);
      busRequest = v.req; busCommandIn = v.cmd;
      snoopRequest = v.sreq; snoopShared = v.ssh; snoopOwned = v.sow;
      exp_q.push_back(v);
      @(negedge clock);
      chk({t, "_grant"}, busGrant, exp_q[0].grant);
      chk({t, "_snoopValid"}, snoopValid, 1);
      chk({t, "_cmd"}, commandOut, exp_q[0].ecmd);
      busRequest = '0;
      busRelease = v.grant;
      @(negedge clock);
      e = exp_q.pop_front();
      chk({t, "_grant_hold"}, busGrant, e.grant);
      chk({t, "_cmd_hold"}, commandOut, e.ecmd);
      chk({t, "_snoopValid_off"}, snoopValid, 0);
      chk({t, "_sharedIn"}, sharedIn, e.sh_e);
      chk({t, "_ownedIn"}, ownedIn, e.ow_e);
      chk({t, "_supplier"}, supplierSelect, e.supp);
      chk({t, "_memSupply"}, memorySupply, e.mem);
      busRelease = ~e.grant;
      @(negedge clock);
      chk({t, "_grant_nongrantee_rel"}, busGrant, e.grant);
      busRelease = e.grant;
      @(negedge clock);
      idle_inputs();
      check_cleared({t, "_end"});
   endtask

   initial begin
      vecs[0] = '{req:4'b0010, cmd:8'h04, sreq:4'b0000, ssh:4'b0000, sow:4'b0000,
                  grant:4'b0010, ecmd:2'd1, sh_e:1'b0, ow_e:1'b0, supp:4'b0000, mem:1'b1};
      vecs[1] = '{req:4'b0010, cmd:8'h04, sreq:4'b1100, ssh:4'b1100, sow:4'b0100,
                  grant:4'b0010, ecmd:2'd1, sh_e:1'b1, ow_e:1'b1, supp:4'b0100, mem:1'b0};
      vecs[2] = '{req:4'b1000, cmd:8'hC0, sreq:4'b0001, ssh:4'b1001, sow:4'b0000,
                  grant:4'b1000, ecmd:2'd3, sh_e:1'b0, ow_e:1'b0, supp:4'b0000, mem:1'b0};
      vecs[3] = '{req:4'b0001, cmd:8'h02, sreq:4'b0001, ssh:4'b0001, sow:4'b0001,
                  grant:4'b0001, ecmd:2'd2, sh_e:1'b0, ow_e:1'b0, supp:4'b0000, mem:1'b1};
      vecs[4] = '{req:4'b0101, cmd:8'h21, sreq:4'b1011, ssh:4'b0100, sow:4'b1000,
                  grant:4'b0100, ecmd:2'd2, sh_e:1'b0, ow_e:1'b1, supp:4'b0001, mem:1'b0};
      vecs[5] = '{req:4'b0011, cmd:8'h09, sreq:4'b0110, ssh:4'b0010, sow:4'b0000,
                  grant:4'b0001, ecmd:2'd1, sh_e:1'b1, ow_e:1'b0, supp:4'b0010, mem:1'b0};

      reset = 1'b1;
      idle_inputs();
      busRequest = 4'b1111;
      @(negedge clock);
      @(negedge clock);
      check_cleared("reset");
      busRequest = '0;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Round-robin from reset with all four requesting continuously.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      busRequest = 4'b1111; busCommandIn = 8'h55;
      grant_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int t = 0; t < 5; t++) begin
         logic [N-1:0] g;
         int waited;
         waited = 0;
         @(negedge clock);
         while (busGrant == '0 && waited < 8) begin
            @(negedge clock);
            waited++;
         end
         g = grant_q.pop_front();
         chk($sformatf("rr_grant%0d", t), busGrant, g);
         chk($sformatf("rr_latency%0d", t), waited, 0);
         @(negedge clock);
         @(negedge clock);
         busRelease = g;
         @(negedge clock);
         busRelease = '0;
         chk($sformatf("rr_gap%0d", t), busGrant, 0);
      end
      idle_inputs();

      // Asynchronous reset in TRANSFER, then a fresh grant afterwards.
      @(negedge clock);
      busRequest = 4'b0100; busCommandIn = 8'h20;
      @(negedge clock);
      busRequest = '0;
      @(negedge clock);
      chk("rst_pre_grant", busGrant, 4'b0100);
      reset = 1'b1;
      #1;
      chk("rst_async_grant", busGrant, 0);
      chk("rst_async_cmd", commandOut, 0);
      @(negedge clock);
      reset = 1'b0;
      busRequest = 4'b1000; busCommandIn = 8'h40;
      @(negedge clock);
      chk("rst_after_grant", busGrant, 4'b1000);
      chk("rst_after_cmd", commandOut, 1);
      busRequest = '0;
      @(negedge clock);
      busRelease = 4'b1000;
      @(negedge clock);
      busRelease = '0;
      check_cleared("rst_done");

      // Transfer without release.
      @(negedge clock);
      busRequest = 4'b0010; busCommandIn = 8'h04;
      @(negedge clock);
      busRequest = '0;
      @(negedge clock);
`ifdef BUS_TIMEOUT_EN
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("to_early%0d", k), busTimeout, 0);
         @(negedge clock);
      end
      chk("to_pulse", busTimeout, 1);
      chk("to_pulse_grant", busGrant, 4'b0010);
      @(negedge clock);
      check_cleared("to_idle");
`else
      for (int k = 0; k < 20; k++) begin
         if (k % 5 == 0) begin
            chk($sformatf("noto_grant%0d", k), busGrant, 4'b0010);
            chk($sformatf("noto_flag%0d", k), busTimeout, 0);
         end
         @(negedge clock);
      end
      busRelease = 4'b0010;
      @(negedge clock);
      busRelease = '0;
      check_cleared("noto_end");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
